// File: rtl/blackjack_main.sv
// Single-player Blackjack for the DE2-115: button conditioning, LFSR card source,
// shuffle/deal/player/dealer/result sequencer, seven-segment totals and outcome LEDs.
module blackjack_main #(
  parameter logic [19:0] SIM_DEBOUNCE_TIMER = 20'd1_000_000,
  parameter logic [26:0] SIM_GAME_TIMER     = 27'd50_000_000
) (
  input  logic        CLOCK_50,
  input  logic [3:0]  KEY,
  output logic [17:0] LEDR,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1,
  output logic [6:0]  HEX4,
  output logic [6:0]  HEX5
);

  typedef enum logic [3:0] {
    SHUFFLE = 4'd0, DEAL_P1 = 4'd1, DEAL_D1 = 4'd2, DEAL_P2 = 4'd3,
    DEAL_D2 = 4'd4, PLAYER  = 4'd5, DEALER  = 4'd6, RESULT  = 4'd7
  } state_t;

  typedef struct packed {
    state_t      state;
    logic [26:0] timer;
    logic [4:0]  p_hard;
    logic        p_ace;
    logic [4:0]  d_hard;
    logic        d_ace;
    logic [3:0]  d_first;
    logic        hit_pend;
    logic        p_bust;
    logic        d_bust;
    logic        p_win;
    logic        d_win;
    logic        push;
  } game_t;

  function automatic logic [4:0] add_card(input logic [4:0] hard, input logic [3:0] val);
    logic [5:0] sum;
    sum = {1'b0, hard} + {2'b00, val};
    return (sum > 6'd31) ? 5'd31 : sum[4:0];
  endfunction

  function automatic logic [4:0] hand_total(input logic [4:0] hard, input logic ace);
    return (ace && hard <= 5'd11) ? hard + 5'd10 : hard;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Returns {tens, units} segment patterns; a zero tens digit is blanked.
  function automatic logic [13:0] show(input logic [4:0] v);
    logic [3:0] tens;
    logic [3:0] units;
    if (v >= 5'd30) begin
      tens = 4'd3; units = 4'(v - 5'd30);
    end else if (v >= 5'd20) begin
      tens = 4'd2; units = 4'(v - 5'd20);
    end else if (v >= 5'd10) begin
      tens = 4'd1; units = 4'(v - 5'd10);
    end else begin
      tens = 4'd0; units = v[3:0];
    end
    return {(tens == 4'd0) ? 7'h7F : seg7(tens), seg7(units)};
  endfunction

  logic        rst_meta;
  logic        rst;
  logic [1:0]  btn_meta;
  logic [1:0]  btn_sync;
  logic [1:0]  btn_level;
  logic [1:0]  btn_level_q;
  logic [19:0] btn_cnt [2];
  logic        hit_press;
  logic        stay_press;
  logic [15:0] lfsr;
  logic [3:0]  rank;
  logic [3:0]  card_val;
  logic        card_ok;
  game_t       g;
  game_t       g_n;
  logic [4:0]  p_total;
  logic [4:0]  d_total;
  logic [4:0]  d_shown;
  logic        p_over;
  logic        d_over;
  logic        timer_done;
  logic        unused_key;

  assign unused_key = KEY[3];

  // NOTE: sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    rst_meta <= ~KEY[0];
    rst      <= rst_meta;
  end

  // Index 0 = hit (KEY[1]), index 1 = stay (KEY[2]); levels idle high.
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      btn_meta    <= 2'b11;
      btn_sync    <= 2'b11;
      btn_level   <= 2'b11;
      btn_level_q <= 2'b11;
      btn_cnt     <= '{default: '0};
    end else begin
      btn_meta    <= KEY[2:1];
      btn_sync    <= btn_meta;
      btn_level_q <= btn_level;
      for (int i = 0; i < 2; i++) begin
        if (btn_sync[i] == btn_level[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == SIM_DEBOUNCE_TIMER - 20'd2) begin
          btn_level[i] <= btn_sync[i];
          btn_cnt[i]   <= '0;
        end else begin
          btn_cnt[i] <= btn_cnt[i] + 20'd1;
        end
      end
    end
  end

  assign {stay_press, hit_press} = btn_level_q & ~btn_level;

  always_ff @(posedge CLOCK_50) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign rank     = lfsr[3:0];
  assign card_ok  = (rank != 4'd0) && (rank <= 4'd13);
  assign card_val = (rank > 4'd10) ? 4'd10 : rank;

  assign p_total    = hand_total(g.p_hard, g.p_ace);
  assign d_total    = hand_total(g.d_hard, g.d_ace);
  assign p_over     = p_total > 5'd21;
  assign d_over     = d_total > 5'd21;
  assign timer_done = g.timer == SIM_GAME_TIMER;

  always_ff @(posedge CLOCK_50) begin
    if (rst) g <= '0;
    else     g <= g_n;
  end

  always_comb begin
    // NOTE: g_n starts as g so every path assigns every field and no latch is inferred.
    g_n = g;
    case (g.state)
      SHUFFLE, DEAL_P1, DEAL_D1, DEAL_P2, DEAL_D2: begin
        if (!timer_done) begin
          g_n.timer = g.timer + 27'd1;
        end else if (card_ok) begin
          g_n.timer = '0;
          case (g.state)
            SHUFFLE: g_n.state = DEAL_P1;
            DEAL_P1, DEAL_P2: begin
              g_n.p_hard = add_card(g.p_hard, card_val);
              g_n.p_ace  = g.p_ace | (card_val == 4'd1);
              g_n.state  = (g.state == DEAL_P1) ? DEAL_D1 : DEAL_D2;
            end
            default: begin
              g_n.d_hard = add_card(g.d_hard, card_val);
              g_n.d_ace  = g.d_ace | (card_val == 4'd1);
              if (g.state == DEAL_D1) begin
                g_n.d_first = card_val;
                g_n.state   = DEAL_P2;
              end else begin
                g_n.state = PLAYER;
              end
            end
          endcase
        end
      end
      PLAYER: begin
        if (p_over) begin
          g_n.state = RESULT;
        end else if (p_total == 5'd21) begin
          g_n.state = DEALER;
        end else if (hit_press || g.hit_pend) begin
          // A hit landing on a rejected rank waits here for the next valid draw.
          g_n.hit_pend = !card_ok;
          if (card_ok) begin
            g_n.p_hard = add_card(g.p_hard, card_val);
            g_n.p_ace  = g.p_ace | (card_val == 4'd1);
          end
        end else if (stay_press) begin
          g_n.state = DEALER;
        end
      end
      DEALER: begin
        if (!timer_done) begin
          g_n.timer = g.timer + 27'd1;
        end else if (d_total >= 5'd17) begin
          g_n.state = RESULT;
        end else if (card_ok) begin
          g_n.d_hard = add_card(g.d_hard, card_val);
          g_n.d_ace  = g.d_ace | (card_val == 4'd1);
          g_n.timer  = '0;
        end
      end
      RESULT: if (hit_press) g_n = '0;
      default: g_n = '0;
    endcase

    if (g_n.state == RESULT && g.state != RESULT) begin
      g_n.p_bust = p_over;
      g_n.d_bust = d_over;
      g_n.p_win  = !p_over && (d_over || p_total > d_total);
      g_n.d_win  = p_over || (!d_over && d_total > p_total);
      g_n.push   = !p_over && !d_over && (p_total == d_total);
    end
  end

  // The hole card stays hidden until the dealer starts playing.
  assign d_shown = (g.state == DEAL_D2 || g.state == PLAYER)
                 ? hand_total({1'b0, g.d_first}, g.d_first == 4'd1) : d_total;

  assign {HEX1, HEX0} = show(p_total);
  assign {HEX5, HEX4} = show(d_shown);
  assign LEDR = {g.state, 9'd0, g.d_bust, g.p_bust, g.push, g.d_win, g.p_win};

endmodule

// File: tb/tb_blackjack_main.sv
// Directed bench for blackjack_main: reset state, deal, debounced hit/stay,
// dealer play, outcome consistency with the displayed totals, bust and mid-game reset.
module tb_blackjack_main;

  localparam logic [19:0] DB_CYCLES   = 20'd5;
  localparam logic [26:0] GAME_CYCLES = 27'd10;

  logic        clk = 1'b0;
  logic [3:0]  key = 4'hF;
  logic [17:0] ledr;
  logic [6:0]  hex0, hex1, hex4, hex5;
  int          checks = 0;
  int          errors = 0;
  int          dealer_cycles = 0;

  blackjack_main #(
    .SIM_DEBOUNCE_TIMER(DB_CYCLES),
    .SIM_GAME_TIMER(GAME_CYCLES)
  ) dut (
    .CLOCK_50(clk),
    .KEY(key),
    .LEDR(ledr),
    .HEX0(hex0),
    .HEX1(hex1),
    .HEX4(hex4),
    .HEX5(hex5)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (ledr[17:14] == 4'd6) dealer_cycles <= dealer_cycles + 1;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic check_true(input string tag, input bit cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed 0 expected 1", tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int btn, input int len);
    key[btn] = 1'b0;
    tick(len);
    key[btn] = 1'b1;
    tick(10);
  endtask

  function automatic int state_code();
    return int'(ledr[17:14]);
  endfunction

  function automatic int seg_digit(input logic [6:0] s);
    case (s)
      7'h40: return 0;
      7'h79: return 1;
      7'h24: return 2;
      7'h30: return 3;
      7'h19: return 4;
      7'h12: return 5;
      7'h02: return 6;
      7'h78: return 7;
      7'h00: return 8;
      7'h10: return 9;
      7'h7F: return 10;
      default: return -1;
    endcase
  endfunction

  // Decoded two-digit value, or -1 when the pattern pair is not a legal display.
  function automatic int shown(input logic [6:0] tens_seg, input logic [6:0] units_seg);
    int t;
    int u;
    t = seg_digit(tens_seg);
    u = seg_digit(units_seg);
    if (tens_seg == 7'h40 || t < 0 || u < 0 || u == 10) return -1;
    if (t == 10) t = 0;
    return t * 10 + u;
  endfunction

  task automatic wait_state(input int s, input int limit, input string tag);
    int n;
    n = 0;
    while (state_code() != s && n < limit) begin
      tick(1);
      n++;
    end
    check(tag, state_code(), s);
  endtask

  task automatic wait_turn(input string tag);
    int n;
    n = 0;
    while (state_code() < 5 && n < 300) begin
      tick(1);
      n++;
    end
    check_true(tag, state_code() >= 5);
  endtask

  task automatic check_result(input string tag);
    int pt;
    int dt;
    logic [2:0] exp_out;
    pt = shown(hex1, hex0);
    dt = shown(hex5, hex4);
    exp_out[0] = (pt <= 21) && (dt > 21 || pt > dt);
    exp_out[1] = (pt > 21) || (dt <= 21 && dt > pt);
    exp_out[2] = (pt <= 21) && (dt <= 21) && (pt == dt);
    check({tag, "_outcome"}, int'(ledr[2:0]), int'(exp_out));
    check_true({tag, "_one_hot"}, $countones(ledr[2:0]) == 1);
    check({tag, "_player_bust"}, int'(ledr[3]), int'(pt > 21));
    check({tag, "_dealer_bust"}, int'(ledr[4]), int'(dt > 21));
    check({tag, "_unused_leds"}, int'(ledr[13:5]), 0);
  endtask

  initial begin
    int pt;
    int dt;
    int hard0;
    int dc0;
    int hits;
    bit found;

    key = 4'b1110;
    tick(5);
    key[0] = 1'b1;
    tick(1);
    check("reset_ledr", int'(ledr), 0);
    check("reset_hex0", int'(hex0), 'h40);
    check("reset_hex1", int'(hex1), 'h7F);
    check("reset_hex4", int'(hex4), 'h40);
    check("reset_hex5", int'(hex5), 'h7F);

    #2000;
    pt = shown(hex1, hex0);
    dt = shown(hex5, hex4);
    check_true("deal_state", state_code() == 5 || (state_code() >= 6 && pt == 21));
    check_true("deal_player_total", pt >= 2 && pt <= 21);
    check_true("deal_dealer_shown",
               (state_code() == 5) ? (dt >= 1 && dt <= 11) : (dt >= 2 && dt <= 31));

    if (state_code() == 5) begin
      hard0 = int'(dut.g.p_hard);
      press(1, 3);
      check("glitch_no_card", int'(dut.g.p_hard), hard0);
      check("glitch_state", state_code(), 5);
      press(1, 5);
      check_true("hit_one_card", int'(dut.g.p_hard) - hard0 >= 1 && int'(dut.g.p_hard) - hard0 <= 10);
    end
    if (state_code() == 5) begin
      key[2] = 1'b0;
      tick(5);
      key[2] = 1'b1;
      wait_state(6, 20, "stay_to_dealer");
    end
    wait_state(7, 400, "game1_result");
    check_result("game1");
    if (!ledr[3]) check_true("game1_dealer_stands", shown(hex5, hex4) >= 17);

    found = 1'b0;
    for (int gm = 0; gm < 8 && !found; gm++) begin
      press(1, 5);
      check("restart_state", state_code(), 0);
      check("restart_flags", int'(ledr[4:0]), 0);
      wait_turn("restart_deal");
      dc0 = dealer_cycles;
      hits = 0;
      while (state_code() == 5 && hits < 12) begin
        press(1, 5);
        hits++;
      end
      if (state_code() == 7 && ledr[3]) begin
        found = 1'b1;
        check("bust_dealer_idle", dealer_cycles - dc0, 0);
      end else begin
        wait_state(7, 400, "nonbust_result");
      end
    end
    check_true("bust_found", found);
    check("bust_state", state_code(), 7);
    check("bust_led3", int'(ledr[3]), 1);
    check("bust_led1", int'(ledr[1]), 1);
    check_true("bust_player_over", shown(hex1, hex0) > 21);
    check_true("bust_dealer_two_cards", shown(hex5, hex4) <= 21);
    check_result("bust");

    press(1, 5);
    wait_turn("reset_game_deal");
    if (state_code() == 5) begin
      key[2] = 1'b0;
      tick(5);
      key[2] = 1'b1;
    end
    wait_state(6, 40, "reset_game_dealer");
    key[0] = 1'b0;
    tick(3);
    check("dealer_reset_ledr", int'(ledr), 0);
    check("dealer_reset_hex0", int'(hex0), 'h40);
    check("dealer_reset_hex1", int'(hex1), 'h7F);
    check("dealer_reset_hex4", int'(hex4), 'h40);
    check("dealer_reset_hex5", int'(hex5), 'h7F);
    key[0] = 1'b1;
    tick(5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

endmodule
